wb_result_sel_stage: RTL and testbench
======================================

Name: wb_result_sel_stage

Overview:
- Parametrised MEM->WB writeback stage and the next generation of the jump/ALU result select.
- Selects among ALU result, link address (PC + INSTR_BYTES), load data (size/sign extended) and upper immediate, then registers the result into WB.
- Adds a valid/ready handshake, a load-wait FSM for variable-latency data memory, and flush.
- Sits between the MEM stage and the register-file write port.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- INSTR_BYTES, 4, link-address increment.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  MEM-stage instruction present.
- in_ready  out  1  stage can accept this cycle.
- wb_sel  in  2  0=ALU, 1=LINK, 2=LOAD, 3=IMM.
- alu_result  in  XLEN  ALU output; low bits also give the load byte offset.
- pc  in  XLEN  instruction PC.
- imm  in  XLEN  upper immediate.
- rd  in  REG_AW  destination register.
- reg_we  in  1  instruction writes rd.
- ld_size  in  2  0=byte, 1=half, 2=word, 3=dword (XLEN=64 only).
- ld_unsigned  in  1  zero- rather than sign-extend.
- mem_rdata  in  XLEN  raw aligned data-memory word.
- mem_rdata_valid  in  1  mem_rdata valid this cycle.
- flush  in  1  kill in-flight and incoming instruction.
- wb_valid  out  1  WB outputs valid.
- wb_data  out  XLEN  selected result.
- wb_rd  out  REG_AW  destination.
- wb_we  out  1  register-file write enable (wb_valid & reg_we).
- busy  out  1  FSM in WAIT_LOAD.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; wb_valid=0, wb_data=0, wb_rd=0, wb_we=0, busy=0. Reset mid-load abandons the load; a later mem_rdata_valid in IDLE is ignored.
- FSM states:
  - IDLE: in_ready=1. Accept occurs when in_valid=1 and flush=0.
  - Non-load accept: wb_* registered next edge, so latency is 1 cycle. wb_valid is a 1-cycle pulse per instruction.
  - LOAD accept: latch rd, reg_we, ld_size, ld_unsigned and offset=alu_result[log2(XLEN/8)-1:0], then go to WAIT_LOAD. If mem_rdata_valid is already 1 in the accept cycle, complete directly: wb_* registered next edge, state stays IDLE.
  - WAIT_LOAD: in_ready=0, busy=1. On mem_rdata_valid, extract the field at the latched offset, extend it, register to wb_* and return to IDLE. Minimum load latency is 1 cycle after data; there is no timeout.
- Flush:
  - In IDLE: no accept; wb_valid=0 next cycle.
  - In WAIT_LOAD: return to IDLE, no writeback.
  - flush and mem_rdata_valid in the same cycle: flush wins.
- Result arithmetic:
  - LINK = pc + INSTR_BYTES, modulo 2^XLEN (pc all-ones wraps).
  - IMM passes through unchanged.
  - Load extraction: byte = mem_rdata[8*off +: 8]; half uses off aligned down to 2; word uses off aligned down to 4. Sign-extend from the field MSB unless ld_unsigned.
  - ld_size=3 with XLEN=32 is treated as word.
- wb_we = 0 whenever wb_valid = 0, regardless of the registered reg_we.

Optional Feature:
- Macro: WB_MISALIGN_TRAP_EN.
- Defined:
  - Adds output wb_misalign (1 bit, reset 0).
  - A load whose offset is not aligned to its size sets wb_misalign=1 with wb_valid=1 and forces wb_we=0.
  - wb_data holds the extracted value computed as if aligned.
- Undefined:
  - Port is absent.
  - Misaligned offsets are silently aligned down and written back normally.

Decomposition:
- Shared package (pipeline_pkg): wb_sel encoding enum (WB_ALU, WB_LINK, WB_LOAD, WB_IMM), ld_size enum (LD_B, LD_H, LD_W, LD_D), FSM state enum.
- One natural sub-module: load_extend. It is combinational and does field extraction plus sign/zero extension, parametrised by XLEN.

Test Plan:
- wb_sel=1, pc=0x0000_1000, rd=1, reg_we=1 -> next cycle wb_valid=1, wb_data=0x0000_1004, wb_we=1.
- wb_sel=1, pc=0xFFFF_FFFC -> wb_data=0x0000_0000 (wrap).
- LOAD byte, offset 3, signed; mem_rdata 2 cycles later = 0x80AA_BBCC -> busy=1 and in_ready=0 for 2 cycles, then wb_data=0xFFFF_FF80. Same stimulus with ld_unsigned=1 -> 0x0000_0080.
- LOAD half, offset 2, mem_rdata=0x1234_5678 arriving in the accept cycle -> wb_data=0x0000_1234 after 1 cycle, no WAIT_LOAD.
- LOAD in WAIT_LOAD; flush and mem_rdata_valid asserted together -> wb_valid stays 0, state back to IDLE, next ALU op accepted normally.
- rst_n=0 during WAIT_LOAD, then mem_rdata_valid=1 after release -> all outputs 0 and no writeback. With WB_MISALIGN_TRAP_EN, a half load at offset 1 -> wb_misalign=1, wb_we=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared encodings for the MEM->WB result select and load extension.
// Enums for wb_sel, load size and the writeback FSM, plus a size mask helper.
package pipeline_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LINK = 2'd1,
    WB_LOAD = 2'd2,
    WB_IMM  = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2,
    LD_D = 2'd3
  } ld_size_e;

  typedef enum logic {
    S_IDLE      = 1'b0,
    S_WAIT_LOAD = 1'b1
  } wb_state_e;

  // Byte-offset mask covering one access of the given size.
  // A dword on a 32-bit datapath degrades to a word.
  function automatic logic [2:0] size_mask(
    input ld_size_e    s,
    input int unsigned xlen
  );
    case (s)
      LD_B:    size_mask = 3'd0;
      LD_H:    size_mask = 3'd1;
      LD_W:    size_mask = 3'd3;
      default: size_mask = (xlen > 32) ? 3'd7 : 3'd3;
    endcase
  endfunction

endpackage

// File: rtl/wb_result_sel_stage_load_extend.sv
// Load field extraction and sign/zero extension.
// Offsets are aligned down to the access size before the field is taken.
import pipeline_pkg::*;

module load_extend #(
  parameter int XLEN = 32,
  parameter int OW   = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] data,
  input  logic [OW-1:0]   off,
  input  ld_size_e        size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] result
);

  logic [2:0]      mask;
  logic [2:0]      off3;
  logic [2:0]      al3;
  logic [XLEN-1:0] sh;
  logic            fill;
  int              nbits;

  // Shift the field to bit 0, then fill above its MSB.
  always_comb begin
    mask  = size_mask(size, XLEN);
    off3  = 3'(off);
    al3   = off3 & ~mask;
    sh    = data >> {al3, 3'b000};
    nbits = (int'(mask) + 1) * 8;
    fill  = 1'b0;
    for (int i = 0; i < XLEN; i++) begin
      if (i == nbits - 1) fill = ~is_unsigned & sh[i];
    end
    result = '0;
    for (int i = 0; i < XLEN; i++) begin
      result[i] = (i < nbits) ? sh[i] : fill;
    end
  end

endmodule

// File: rtl/wb_result_sel_stage.sv
// MEM->WB result select with handshake, load-wait FSM and flush.
// Optional macro WB_MISALIGN_TRAP_EN adds wb_misalign and suppresses its write.
import pipeline_pkg::*;

module wb_result_sel_stage #(
  parameter int XLEN        = 32,
  parameter int INSTR_BYTES = 4,
  parameter int REG_AW      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        wb_sel,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   imm,
  input  logic [REG_AW-1:0] rd,
  input  logic              reg_we,
  input  logic [1:0]        ld_size,
  input  logic              ld_unsigned,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_rdata_valid,
  input  logic              flush,
  output logic              wb_valid,
  output logic [XLEN-1:0]   wb_data,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_we,
`ifdef WB_MISALIGN_TRAP_EN
  output logic              wb_misalign,
`endif
  output logic              busy
);

  localparam int OW = $clog2(XLEN / 8);

  wb_state_e         state_q;
  logic              wb_valid_q;
  logic [XLEN-1:0]   wb_data_q;
  logic [REG_AW-1:0] wb_rd_q;
  logic              we_q;

  logic [REG_AW-1:0] rd_l;
  logic              we_l;
  ld_size_e          size_l;
  logic              uns_l;
  logic [OW-1:0]     off_l;

  wb_sel_e           sel;
  ld_size_e          cur_size;
  logic              cur_uns;
  logic [OW-1:0]     cur_off;
  logic [XLEN-1:0]   ld_data;
  logic [XLEN-1:0]   sel_data;
  logic              cur_mis;

  // Load controls come from the port in IDLE, from the latch while waiting.
  always_comb begin
    sel      = wb_sel_e'(wb_sel);
    cur_size = ld_size_e'(ld_size);
    cur_uns  = ld_unsigned;
    cur_off  = alu_result[OW-1:0];
    if (state_q == S_WAIT_LOAD) begin
      cur_size = size_l;
      cur_uns  = uns_l;
      cur_off  = off_l;
    end
  end

  // Non-load result select; LINK wraps modulo 2^XLEN.
  always_comb begin
    sel_data = alu_result;
    unique case (1'b1)
      (sel == WB_LINK): sel_data = pc + XLEN'(INSTR_BYTES);
      (sel == WB_IMM):  sel_data = imm;
      default:          sel_data = alu_result;
    endcase
  end

  load_extend #(
    .XLEN (XLEN),
    .OW   (OW)
  ) u_load_extend (
    .data        (mem_rdata),
    .off         (cur_off),
    .size        (cur_size),
    .is_unsigned (cur_uns),
    .result      (ld_data)
  );

`ifdef WB_MISALIGN_TRAP_EN
  logic [2:0] mis_mask;
  logic       mis_q;

  // Offset bits inside the access size mark a misaligned load.
  always_comb begin
    mis_mask = size_mask(cur_size, XLEN);
    cur_mis  = |(3'(cur_off) & mis_mask);
  end

  assign wb_misalign = mis_q;
`else
  assign cur_mis = 1'b0;
`endif

  // Writeback FSM: accept, wait for load data, register the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      we_q       <= 1'b0;
      rd_l       <= '0;
      we_l       <= 1'b0;
      size_l     <= LD_B;
      uns_l      <= 1'b0;
      off_l      <= '0;
`ifdef WB_MISALIGN_TRAP_EN
      mis_q      <= 1'b0;
`endif
    end else begin
      wb_valid_q <= 1'b0;
`ifdef WB_MISALIGN_TRAP_EN
      mis_q      <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (in_valid && !flush) begin
            if (sel == WB_LOAD) begin
              rd_l   <= rd;
              we_l   <= reg_we;
              size_l <= cur_size;
              uns_l  <= ld_unsigned;
              off_l  <= cur_off;
              if (mem_rdata_valid) begin
                wb_valid_q <= 1'b1;
                wb_data_q  <= ld_data;
                wb_rd_q    <= rd;
                we_q       <= reg_we & ~cur_mis;
`ifdef WB_MISALIGN_TRAP_EN
                mis_q      <= cur_mis;
`endif
              end else begin
                state_q <= S_WAIT_LOAD;
              end
            end else begin
              wb_valid_q <= 1'b1;
              wb_data_q  <= sel_data;
              wb_rd_q    <= rd;
              we_q       <= reg_we;
            end
          end
        end
        S_WAIT_LOAD: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else if (mem_rdata_valid) begin
            state_q    <= S_IDLE;
            wb_valid_q <= 1'b1;
            wb_data_q  <= ld_data;
            wb_rd_q    <= rd_l;
            we_q       <= we_l & ~cur_mis;
`ifdef WB_MISALIGN_TRAP_EN
            mis_q      <= cur_mis;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q == S_WAIT_LOAD);
  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_data_q;
  assign wb_rd    = wb_rd_q;
  assign wb_we    = wb_valid_q & we_q;

endmodule

// File: tb/tb_wb_result_sel_stage.sv
// Scoreboard bench for wb_result_sel_stage (XLEN=32).
// Driver pushes expected writebacks; a negedge monitor pops and compares.
module tb_wb_result_sel_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  wb_sel = 2'd0;
  logic [31:0] alu_result = '0;
  logic [31:0] pc = '0;
  logic [31:0] imm = '0;
  logic [4:0]  rd = '0;
  logic        reg_we = 1'b0;
  logic [1:0]  ld_size = 2'd0;
  logic        ld_unsigned = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rdata_valid = 1'b0;
  logic        flush = 1'b0;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic        busy;
`ifdef WB_MISALIGN_TRAP_EN
  logic        wb_misalign;
`endif

  wb_result_sel_stage #(
    .XLEN        (32),
    .INSTR_BYTES (4),
    .REG_AW      (5)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .wb_sel          (wb_sel),
    .alu_result      (alu_result),
    .pc              (pc),
    .imm             (imm),
    .rd              (rd),
    .reg_we          (reg_we),
    .ld_size         (ld_size),
    .ld_unsigned     (ld_unsigned),
    .mem_rdata       (mem_rdata),
    .mem_rdata_valid (mem_rdata_valid),
    .flush           (flush),
    .wb_valid        (wb_valid),
    .wb_data         (wb_data),
    .wb_rd           (wb_rd),
    .wb_we           (wb_we),
`ifdef WB_MISALIGN_TRAP_EN
    .wb_misalign     (wb_misalign),
`endif
    .busy            (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  r;
    logic        we;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [4:0] r,
                      input logic we, input logic mis);
    exp_t e;
    e.d = d; e.r = r; e.we = we; e.mis = mis;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] p, input logic [31:0] im,
                       input logic [4:0] r, input logic we);
    wb_sel = s; alu_result = a; pc = p; imm = im; rd = r; reg_we = we;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic load_start(input logic [31:0] a, input logic [1:0] sz,
                            input logic uns, input logic [4:0] r);
    wb_sel = 2'd2; alu_result = a; ld_size = sz; ld_unsigned = uns;
    rd = r; reg_we = 1'b1; in_valid = 1'b1;
  endtask

  // Monitor: every valid writeback must match the oldest expectation.
  always @(negedge clk) begin
    if (wb_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wb act=%h exp=none t=%0t", wb_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_data", wb_data, mon_e.d);
        chk("wb_rd", 32'(wb_rd), 32'(mon_e.r));
        chk("wb_we", 32'(wb_we), 32'(mon_e.we));
`ifdef WB_MISALIGN_TRAP_EN
        chk("wb_misalign", 32'(wb_misalign), 32'(mon_e.mis));
`endif
      end
    end else begin
      chk("we_gated", 32'(wb_we), 32'd0);
    end
  end

  initial begin
    step(); step(); step();
    @(negedge clk);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();

    push(32'h0000_1004, 5'd1, 1'b1, 1'b0);
    issue(2'd1, 32'h0, 32'h0000_1000, 32'h0, 5'd1, 1'b1);
    push(32'h0000_0000, 5'd2, 1'b1, 1'b0);
    issue(2'd1, 32'h0, 32'hFFFF_FFFC, 32'h0, 5'd2, 1'b1);
    push(32'hDEAD_BEEF, 5'd3, 1'b0, 1'b0);
    issue(2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd3, 1'b0);
    push(32'h1234_5000, 5'd4, 1'b1, 1'b0);
    issue(2'd3, 32'h0, 32'h0, 32'h1234_5000, 5'd4, 1'b1);
    step();

    // Byte load, offset 3, data two cycles after accept.
    for (int u = 0; u < 2; u++) begin
      load_start(32'h0000_1003, 2'd0, 1'(u), 5'(5 + u));
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("wait1_busy", 32'(busy), 32'd1);
      chk("wait1_ready", 32'(in_ready), 32'd0);
      step();
      @(negedge clk);
      chk("wait2_busy", 32'(busy), 32'd1);
      chk("wait2_ready", 32'(in_ready), 32'd0);
      mem_rdata = 32'h80AA_BBCC;
      mem_rdata_valid = 1'b1;
      push((u == 0) ? 32'hFFFF_FF80 : 32'h0000_0080, 5'(5 + u), 1'b1, 1'b0);
      step();
      mem_rdata_valid = 1'b0;
      step();
    end

    // Half load with data in the accept cycle.
    load_start(32'h0000_2002, 2'd1, 1'b0, 5'd7);
    mem_rdata = 32'h1234_5678;
    mem_rdata_valid = 1'b1;
    push(32'h0000_1234, 5'd7, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    mem_rdata_valid = 1'b0;
    @(negedge clk);
    chk("fast_ld_busy", 32'(busy), 32'd0);
    step();

    // Signed half at offset 0 and signed word.
    load_start(32'h0000_3000, 2'd1, 1'b0, 5'd8);
    mem_rdata = 32'h0000_F00F;
    mem_rdata_valid = 1'b1;
    push(32'hFFFF_F00F, 5'd8, 1'b1, 1'b0);
    step();
    load_start(32'h0000_3004, 2'd2, 1'b0, 5'd9);
    mem_rdata = 32'h8000_0001;
    push(32'h8000_0001, 5'd9, 1'b1, 1'b0);
    step();

    // Misaligned half at offset 1: aligned down to offset 0.
    load_start(32'h0000_4001, 2'd1, 1'b0, 5'd10);
    mem_rdata = 32'hAAAA_8001;
`ifdef WB_MISALIGN_TRAP_EN
    push(32'hFFFF_8001, 5'd10, 1'b0, 1'b1);
`else
    push(32'hFFFF_8001, 5'd10, 1'b1, 1'b0);
`endif
    step();
    in_valid = 1'b0;
    mem_rdata_valid = 1'b0;
    step();

    // Flush beats data in WAIT_LOAD.
    load_start(32'h0000_5000, 2'd2, 1'b0, 5'd11);
    step();
    in_valid = 1'b0;
    step();
    flush = 1'b1;
    mem_rdata_valid = 1'b1;
    step();
    flush = 1'b0;
    mem_rdata_valid = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    chk("flush_valid", 32'(wb_valid), 32'd0);
    push(32'h0000_0055, 5'd12, 1'b1, 1'b0);
    issue(2'd0, 32'h0000_0055, 32'h0, 32'h0, 5'd12, 1'b1);

    // Flush in IDLE blocks the accept.
    flush = 1'b1;
    issue(2'd0, 32'h0000_0066, 32'h0, 32'h0, 5'd13, 1'b1);
    flush = 1'b0;
    step();

    // Reset mid-load, then stale data after release.
    load_start(32'h0000_6000, 2'd2, 1'b0, 5'd14);
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    mem_rdata = 32'h7777_7777;
    mem_rdata_valid = 1'b1;
    step();
    mem_rdata_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(wb_valid), 32'd0);
    chk("post_rst_data", wb_data, 32'd0);
    chk("post_rst_rd", 32'(wb_rd), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
